// File: rtl/pool_result_collector.sv
// ============================================================================
//  Module      : pool_result_collector
//  Description : Collects the raster-ordered stream of pooled words, applies
//                optional ReLU, stores them in an outSize x outSize feature-map
//                buffer and exposes that buffer through a registered read port.
//                Tracks the write position and the running map maximum, and
//                pulses done for one cycle when the map is complete or when the
//                requested map size is invalid.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        clock, all state updates on the rising edge
//    reset_i      asynchronous active-high reset
//    start_i      pulse: begin a new map (honoured in IDLE only)
//    outSize_i    pooled map side, sampled on an accepted start
//    relu_en_i    1: store max(0,x), 0: store x; sampled on an accepted start
//    in_valid_i   pooled word present
//    in_data_i    signed pooled word
//    in_ready_o   word accepted this cycle when in_valid_i is also high
//    rd_addr_i    buffer read address (row*outSize+col)
//    rd_data_o    buffer word, one-cycle latency
//    busy_o       high while collecting
//    done_o       one-cycle completion (or error abort) pulse
//    err_o        sticky invalid-size flag, cleared by the next accepted start
//    row_o/col_o  position of the next word to be written
//    map_max_o    signed maximum of the stored (post-ReLU) words
// ============================================================================
`default_nettype none

module pool_result_collector #(
    parameter int DATA_W  = 16,
    parameter int MAX_OUT = 256,
    parameter int ADDR_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [15:0]              outSize_i,
    input  logic                     relu_en_i,
    input  logic                     in_valid_i,
    input  logic signed [DATA_W-1:0] in_data_i,
    output logic                     in_ready_o,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    output logic signed [DATA_W-1:0] rd_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [15:0]              row_o,
    output logic [15:0]              col_o,
    output logic signed [DATA_W-1:0] map_max_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic signed [DATA_W-1:0] C_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                     state_q, state_d;
    logic [15:0]                outsize_q, outsize_d;
    logic                       relu_q, relu_d;
    logic [31:0]                total_q, total_d;
    logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [15:0]                row_q, row_d;
    logic [15:0]                col_q, col_d;
    logic                       err_q, err_d;
    logic signed [DATA_W-1:0]   max_q, max_d;
    logic signed [DATA_W-1:0]   rd_data_q;

    // Feature-map buffer; intentionally not reset.
    logic [DATA_W-1:0]          mem_q [MAX_OUT];

    logic                       w_accept;
    logic signed [DATA_W-1:0]   w_store;
    logic [31:0]                w_total;
    logic                       w_last;

    assign w_accept = (state_q == S_COLLECT) && in_valid_i;
    assign w_store  = (relu_q && in_data_i[DATA_W-1]) ? '0 : in_data_i;
    assign w_total  = 32'(outSize_i) * 32'(outSize_i);
    assign w_last   = (32'(wr_ptr_q) == (total_q - 32'd1));

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        outsize_d = outsize_q;
        relu_d    = relu_q;
        total_d   = total_q;
        wr_ptr_d  = wr_ptr_q;
        row_d     = row_q;
        col_d     = col_q;
        err_d     = err_q;
        max_d     = max_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    outsize_d = outSize_i;
                    relu_d    = relu_en_i;
                    total_d   = w_total;
                    wr_ptr_d  = '0;
                    row_d     = '0;
                    col_d     = '0;
                    err_d     = 1'b0;
                    max_d     = C_MOST_NEG;
                    // Invalid sizes abort straight to DONE without accepting words.
                    if ((outSize_i == 16'd0) || (w_total > 32'(MAX_OUT))) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (col_q == (outsize_q - 16'd1)) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    if (w_store > max_q) begin
                        max_d = w_store;
                    end
                    if (w_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            outsize_q <= '0;
            relu_q    <= 1'b0;
            total_q   <= '0;
            wr_ptr_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            err_q     <= 1'b0;
            max_q     <= C_MOST_NEG;
        end else begin
            state_q   <= state_d;
            outsize_q <= outsize_d;
            relu_q    <= relu_d;
            total_q   <= total_d;
            wr_ptr_q  <= wr_ptr_d;
            row_q     <= row_d;
            col_q     <= col_d;
            err_q     <= err_d;
            max_q     <= max_d;
        end
    end

    // ------------------------------------------------------------------
    // Buffer write and registered read. A read of the address written in
    // the same cycle returns the previous word (read-before-write).
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= w_store;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
        end else if (32'(rd_addr_i) < 32'(MAX_OUT)) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready_o = (state_q == S_COLLECT);
    assign busy_o     = (state_q == S_COLLECT);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;
    assign row_o      = row_q;
    assign col_o      = col_q;
    assign map_max_o  = max_q;
    assign rd_data_o  = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_pool_result_collector.sv
// ============================================================================
//  Module      : tb_pool_result_collector
//  Description : Self-checking bench for pool_result_collector. Random and
//                directed maps are checked against a queue-based reference
//                model of the stored map, its position and its maximum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool_result_collector;

    localparam int DATA_W  = 16;
    localparam int MAX_OUT = 256;
    localparam int ADDR_W  = 8;

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic [15:0]              outSize;
    logic                     relu_en;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [15:0]              row;
    logic [15:0]              col;
    logic signed [DATA_W-1:0] map_max;

    int n_tests = 0;
    int n_fail  = 0;

    // Words to feed for the next map, and the expected buffer image.
    logic signed [DATA_W-1:0] stim[$];
    logic signed [DATA_W-1:0] exp_buf [MAX_OUT];

    pool_result_collector #(
        .DATA_W (DATA_W),
        .MAX_OUT(MAX_OUT),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .outSize_i (outSize),
        .relu_en_i (relu_en),
        .in_valid_i(in_valid),
        .in_data_i (in_data),
        .in_ready_o(in_ready),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .row_o     (row),
        .col_o     (col),
        .map_max_o (map_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void rand_stim(input int cnt);
        stim.delete();
        for (int i = 0; i < cnt; i++) begin
            stim.push_back(DATA_W'($urandom));
        end
    endfunction

    // Runs one complete map of side n and checks position, completion,
    // maximum and the buffer contents against the model.
    task automatic collect(input int n, input bit relu, input int gap_pct,
                           input bit poke_start, input string name);
        int total;
        int idx;
        int cyc;
        int budget;
        bit poked;
        bit v;
        logic signed [DATA_W-1:0] st;
        logic signed [DATA_W-1:0] emax;
        logic signed [DATA_W-1:0] model[$];
        total  = n * n;
        idx    = 0;
        cyc    = 0;
        budget = total * 20 + 50;
        poked  = 1'b0;
        emax   = 16'sh8000;

        @(negedge clk);
        start    = 1'b1;
        outSize  = 16'(n);
        relu_en  = relu;
        in_valid = 1'b0;
        @(negedge clk);
        // Scramble the configuration inputs to show they were latched.
        start   = 1'b0;
        outSize = 16'd0;
        relu_en = ~relu;
        n_tests++;
        if (busy !== 1'b1 || err !== 1'b0 || map_max !== 16'sh8000) begin
            n_fail++;
            $display("FAIL %s start: busy=%b err=%b max=%0d, want busy=1 err=0 max=-32768",
                     name, busy, err, map_max);
        end

        while (idx < total && cyc < budget) begin
            n_tests++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                row !== 16'(idx / n) || col !== 16'(idx % n)) begin
                n_fail++;
                $display("FAIL %s pos[%0d]: ready=%b busy=%b done=%b row=%0d col=%0d, want 1 1 0 row=%0d col=%0d",
                         name, idx, in_ready, busy, done, row, col, idx / n, idx % n);
            end
            start = 1'b0;
            if (poke_start && !poked && idx == 1) begin
                start   = 1'b1;
                outSize = 16'd3;
                poked   = 1'b1;
            end
            v        = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data  = v ? stim[idx] : DATA_W'($urandom);
            @(negedge clk);
            cyc++;
            if (v) begin
                st = (relu && stim[idx] < 0) ? 16'sd0 : stim[idx];
                model.push_back(st);
                if (st > emax) emax = st;
                idx++;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;

        if (idx < total) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: accepted %0d words, want %0d", name, idx, total);
            return;
        end
        if (gap_pct == 0) begin
            n_tests++;
            if (cyc != total) begin
                n_fail++;
                $display("FAIL %s busy_cycles: got %0d, want %0d", name, cyc, total);
            end
        end

        // DONE cycle
        n_tests++;
        if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
            row !== 16'(n) || col !== 16'd0 || map_max !== emax) begin
            n_fail++;
            $display("FAIL %s done: done=%b ready=%b busy=%b err=%b row=%0d col=%0d max=%0d, want 1 0 0 0 row=%0d col=0 max=%0d",
                     name, done, in_ready, busy, err, row, col, map_max, n, emax);
        end
        // start and a word offered in DONE must both be ignored.
        start    = 1'b1;
        outSize  = 16'd2;
        in_valid = 1'b1;
        in_data  = 16'sh7abc;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: done=%b busy=%b ready=%b, want 0 0 0",
                     name, done, busy, in_ready);
        end

        for (int a = 0; a < total; a++) begin
            exp_buf[a] = model[a];
            rd_addr = ADDR_W'(a);
            @(negedge clk);
            n_tests++;
            if (rd_data !== model[a]) begin
                n_fail++;
                $display("FAIL %s read[%0d]: got %0d, want %0d", name, a, rd_data, model[a]);
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        outSize  = 16'd0;
        relu_en  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_addr  = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0 ||
            row !== 16'd0 || col !== 16'd0 || map_max !== 16'sh8000 || rd_data !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b err=%b ready=%b row=%0d col=%0d max=%0d rd=%0d",
                     busy, done, err, in_ready, row, col, map_max, rd_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        stim = {16'sd5, -16'sd3, 16'sd7, 16'sd1};
        collect(2, 1'b0, 0, 1'b0, "fill");
    endtask

    task automatic test_relu();
        stim = {-16'sd4, 16'sd2, -16'sd1, -16'sd8};
        collect(2, 1'b1, 0, 1'b0, "relu");
    endtask

    task automatic test_gaps();
        rand_stim(9);
        collect(3, 1'b0, 40, 1'b0, "gaps");
    endtask

    task automatic test_start_ignored();
        rand_stim(4);
        collect(2, 1'b0, 20, 1'b1, "start_ign");
    endtask

    task automatic test_error(input int n);
        @(negedge clk);
        start    = 1'b1;
        outSize  = 16'(n);
        in_valid = 1'b1;
        in_data  = 16'sh1234;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 ||
            row !== 16'd0 || col !== 16'd0 || map_max !== 16'sh8000) begin
            n_fail++;
            $display("FAIL err%0d abort: done=%b err=%b busy=%b ready=%b row=%0d col=%0d max=%0d, want 1 1 0 0 0 0 -32768",
                     n, done, err, busy, in_ready, row, col, map_max);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err%0d sticky: done=%b err=%b busy=%b, want 0 1 0", n, done, err, busy);
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = ADDR_W'(a);
            @(negedge clk);
            n_tests++;
            if (rd_data !== exp_buf[a]) begin
                n_fail++;
                $display("FAIL err%0d nowrite[%0d]: got %0d, want %0d", n, a, rd_data, exp_buf[a]);
            end
        end
    endtask

    task automatic test_random_maps();
        int sizes[6];
        sizes[0] = 1;
        sizes[1] = 16;
        for (int k = 2; k < 6; k++) sizes[k] = $urandom_range(15, 1);
        for (int k = 0; k < 6; k++) begin
            rand_stim(sizes[k] * sizes[k]);
            collect(sizes[k], 1'($urandom), 25, 1'b0, "random");
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start   = 1'b1;
        outSize = 16'd2;
        relu_en = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'sd11;
        @(negedge clk);
        in_data = 16'sd22;
        @(negedge clk);
        in_valid = 1'b0;
        exp_buf[0] = 16'sd11;
        exp_buf[1] = 16'sd22;
        n_tests++;
        if (busy !== 1'b1 || row !== 16'd1 || col !== 16'd0 || map_max !== 16'sd22) begin
            n_fail++;
            $display("FAIL midrst pre: busy=%b row=%0d col=%0d max=%0d, want 1 1 0 22",
                     busy, row, col, map_max);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0 ||
            row !== 16'd0 || col !== 16'd0 || map_max !== 16'sh8000 || rd_data !== 16'sd0) begin
            n_fail++;
            $display("FAIL midrst: busy=%b done=%b ready=%b err=%b row=%0d col=%0d max=%0d rd=%0d",
                     busy, done, in_ready, err, row, col, map_max, rd_data);
        end
        @(negedge clk);
        reset = 1'b0;
        rand_stim(4);
        collect(2, 1'b0, 0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        rand_stim(16);
        collect(4, 1'b1, 0, 1'b0, "b2b_a");
        rand_stim(25);
        collect(5, 1'b0, 0, 1'b0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_relu();
        test_gaps();
        test_start_ignored();
        test_error(0);
        test_error(17);
        test_random_maps();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
